// File: rtl/register_status_file_if.sv
// rtl/register_status_file_if.sv - commit and alloc message channels into the register status file
// Dispatch/commit drive the master side; the register status file is the receiver.
interface register_status_file_if #(
  parameter int IDX_W  = 6,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8
);
  logic              commit_en;
  logic [IDX_W-1:0]  commit_dest;
  logic [ID_W-1:0]   commit_id;
  logic [DATA_W-1:0] commit_data;
  logic              commit_reject;

  logic              alloc_en;
  logic [IDX_W-1:0]  alloc_dest;
  logic [ID_W-1:0]   alloc_id;
  logic              alloc_reject;

  modport master (
    output commit_en, commit_dest, commit_id, commit_data,
    input  commit_reject,
    output alloc_en, alloc_dest, alloc_id,
    input  alloc_reject
  );

  modport slave (
    input  commit_en, commit_dest, commit_id, commit_data,
    output commit_reject,
    input  alloc_en, alloc_dest, alloc_id,
    output alloc_reject
  );
endinterface

// File: rtl/register_status_file.sv
// rtl/register_status_file.sv - architectural register file with busy/tag scoreboard
// Commits write data and retire matching producers; dispatch allocs mark registers busy.
module register_status_file #(
  parameter int N_REG  = 64,
  parameter int DATA_W = 32,
  parameter int ID_W   = 8,
  parameter int IDX_W  = $clog2(N_REG),
  parameter int CNT_W  = $clog2(N_REG + 1)
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_flash,
  register_status_file_if.slave  bus,
  input  logic [1:0][IDX_W-1:0]  i_src_logic,
  output logic [1:0]             o_src_ready,
  output logic [1:0][DATA_W-1:0] o_src_data,
  output logic [1:0][ID_W-1:0]   o_src_tag,
  output logic [CNT_W-1:0]       o_busy_count
);

  logic [DATA_W-1:0] r_data [N_REG];
  logic [ID_W-1:0]   r_tag  [N_REG];
  logic [N_REG-1:0]  r_busy;
  logic [CNT_W-1:0]  r_busy_count;

  logic             w_commit_ok;
  logic             w_alloc_ok;
  logic             w_commit_retires;
  logic [N_REG-1:0] w_busy_nxt;
  logic [CNT_W-1:0] w_busy_cnt_nxt;

  assign bus.commit_reject = 1'b0;
  assign bus.alloc_reject  = 1'b0;

  assign w_commit_ok = bus.commit_en && (bus.commit_dest != '0);
  assign w_alloc_ok  = bus.alloc_en && (bus.alloc_dest != '0) && !i_flash;

  // A commit only retires the register if its id is still the latest producer.
  assign w_commit_retires = w_commit_ok && r_busy[bus.commit_dest] &&
                            (r_tag[bus.commit_dest] == bus.commit_id);

  always_comb begin
    w_busy_nxt = r_busy;
    if (i_flash) begin
      w_busy_nxt = '0;
    end else begin
      if (w_commit_retires) w_busy_nxt[bus.commit_dest] = 1'b0;
      // Alloc is applied after commit so it owns busy on a same-register collision.
      if (w_alloc_ok) w_busy_nxt[bus.alloc_dest] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_busy_cnt_nxt = '0;
    for (int k = 0; k < N_REG; k++) begin
      w_busy_cnt_nxt = w_busy_cnt_nxt + CNT_W'(w_busy_nxt[k]);
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_REG; k++) r_data[k] <= '0;
    end else if (w_commit_ok) begin
      r_data[bus.commit_dest] <= bus.commit_data;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_REG; k++) r_tag[k] <= '0;
    end else if (w_alloc_ok) begin
      r_tag[bus.alloc_dest] <= bus.alloc_id;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_busy       <= '0;
      r_busy_count <= '0;
    end else begin
      r_busy       <= w_busy_nxt;
      r_busy_count <= w_busy_cnt_nxt;
    end
  end

  assign o_busy_count = r_busy_count;

  // Reads use pre-edge state, with a bypass from the commit being presented this cycle.
  always_comb begin
    o_src_ready = '0;
    o_src_data  = '0;
    o_src_tag   = '0;
    for (int i = 0; i < 2; i++) begin
      if (i_src_logic[i] == '0) begin
        o_src_ready[i] = 1'b1;
      end else if (!r_busy[i_src_logic[i]]) begin
        o_src_ready[i] = 1'b1;
        o_src_data[i]  = r_data[i_src_logic[i]];
        o_src_tag[i]   = r_tag[i_src_logic[i]];
      end else if (bus.commit_en && (bus.commit_dest == i_src_logic[i]) &&
                   (bus.commit_id == r_tag[i_src_logic[i]])) begin
        o_src_ready[i] = 1'b1;
        o_src_data[i]  = bus.commit_data;
        o_src_tag[i]   = r_tag[i_src_logic[i]];
      end else begin
        o_src_ready[i] = 1'b0;
        o_src_data[i]  = r_data[i_src_logic[i]];
        o_src_tag[i]   = r_tag[i_src_logic[i]];
      end
    end
  end

endmodule

// File: tb/tb_register_status_file.sv
// tb/tb_register_status_file.sv - directed self-checking bench for register_status_file
module tb_register_status_file;
  logic             clk = 1'b0;
  logic             rst;
  logic             flash;
  logic [1:0][5:0]  src_logic;
  logic [1:0]       src_ready;
  logic [1:0][31:0] src_data;
  logic [1:0][7:0]  src_tag;
  logic [6:0]       busy_count;

  int tests_run = 0;
  int tests_failed = 0;

  register_status_file_if bus ();

  register_status_file dut (
    .i_clock      (clk),
    .i_reset      (rst),
    .i_flash      (flash),
    .bus          (bus),
    .i_src_logic  (src_logic),
    .o_src_ready  (src_ready),
    .o_src_data   (src_data),
    .o_src_tag    (src_tag),
    .o_busy_count (busy_count)
  );

  always #5 clk = ~clk;

  task automatic idle();
    flash = 1'b0;
    bus.commit_en = 1'b0; bus.commit_dest = '0; bus.commit_id = '0; bus.commit_data = '0;
    bus.alloc_en = 1'b0; bus.alloc_dest = '0; bus.alloc_id = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); src_logic = '0;
    tick(); tick();
    rst = 1'b0;
    src_logic[0] = 6'd5; src_logic[1] = 6'd63;
    settle();
    tests_run++;
    if (src_ready !== 2'b11) begin tests_failed++; $display("FAIL reset_ready got %b want 11", src_ready); end
    tests_run++;
    if (src_data[0] !== 32'd0 || src_data[1] !== 32'd0) begin tests_failed++; $display("FAIL reset_data got %h %h want 0", src_data[0], src_data[1]); end
    tests_run++;
    if (src_tag[0] !== 8'd0 || src_tag[1] !== 8'd0) begin tests_failed++; $display("FAIL reset_tag got %h %h want 0", src_tag[0], src_tag[1]); end
    tests_run++;
    if (busy_count !== 7'd0) begin tests_failed++; $display("FAIL reset_busy_count got %0d want 0", busy_count); end
    tests_run++;
    if (bus.commit_reject !== 1'b0 || bus.alloc_reject !== 1'b0) begin tests_failed++; $display("FAIL reject got %b %b want 0 0", bus.commit_reject, bus.alloc_reject); end
    bus.commit_en = 1'b1; bus.commit_dest = 6'd0; bus.commit_id = 8'h3; bus.commit_data = 32'hDEAD;
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd0; bus.alloc_id = 8'h4;
    tick();
    src_logic[0] = 6'd0; src_logic[1] = 6'd0;
    settle();
    tests_run++;
    if (src_ready !== 2'b11 || src_data[0] !== 32'd0) begin tests_failed++; $display("FAIL r0_write got ready %b data %h want 11 0", src_ready, src_data[0]); end
    tests_run++;
    if (busy_count !== 7'd0) begin tests_failed++; $display("FAIL r0_alloc_count got %0d want 0", busy_count); end
  endtask

  task automatic test_bypass();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd3; bus.alloc_id = 8'h10;
    src_logic[0] = 6'd3; src_logic[1] = 6'd3;
    settle();
    tests_run++;
    if (src_ready[0] !== 1'b1) begin tests_failed++; $display("FAIL alloc_same_cycle_read got %b want 1", src_ready[0]); end
    tick();
    settle();
    tests_run++;
    if (src_ready[0] !== 1'b0 || src_tag[0] !== 8'h10) begin tests_failed++; $display("FAIL busy_r3 got ready %b tag %h want 0 10", src_ready[0], src_tag[0]); end
    tests_run++;
    if (busy_count !== 7'd1) begin tests_failed++; $display("FAIL busy_count_r3 got %0d want 1", busy_count); end
    bus.commit_en = 1'b1; bus.commit_dest = 6'd3; bus.commit_id = 8'h10; bus.commit_data = 32'h1234;
    settle();
    tests_run++;
    if (src_ready !== 2'b11 || src_data[0] !== 32'h1234 || src_data[1] !== 32'h1234) begin
      tests_failed++; $display("FAIL bypass got ready %b data %h %h want 11 1234", src_ready, src_data[0], src_data[1]);
    end
    tick();
    settle();
    tests_run++;
    if (src_ready[0] !== 1'b1 || src_data[0] !== 32'h1234) begin tests_failed++; $display("FAIL after_commit_r3 got %b %h want 1 1234", src_ready[0], src_data[0]); end
    tests_run++;
    if (busy_count !== 7'd0) begin tests_failed++; $display("FAIL busy_count_after_r3 got %0d want 0", busy_count); end
  endtask

  task automatic test_younger_producer();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd4; bus.alloc_id = 8'd1;
    tick();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd4; bus.alloc_id = 8'd2;
    tick();
    src_logic[0] = 6'd4; src_logic[1] = 6'd0;
    bus.commit_en = 1'b1; bus.commit_dest = 6'd4; bus.commit_id = 8'd1; bus.commit_data = 32'd7;
    settle();
    tests_run++;
    if (src_ready[0] !== 1'b0 || src_tag[0] !== 8'd2) begin tests_failed++; $display("FAIL stale_no_bypass got %b tag %h want 0 02", src_ready[0], src_tag[0]); end
    tick();
    settle();
    tests_run++;
    if (src_ready[0] !== 1'b0 || src_tag[0] !== 8'd2 || busy_count !== 7'd1) begin
      tests_failed++; $display("FAIL stale_commit got ready %b tag %h count %0d want 0 02 1", src_ready[0], src_tag[0], busy_count);
    end
    bus.commit_en = 1'b1; bus.commit_dest = 6'd4; bus.commit_id = 8'd2; bus.commit_data = 32'd9;
    tick();
    settle();
    tests_run++;
    if (src_ready[0] !== 1'b1 || src_data[0] !== 32'd9 || busy_count !== 7'd0) begin
      tests_failed++; $display("FAIL younger_commit got ready %b data %h count %0d want 1 9 0", src_ready[0], src_data[0], busy_count);
    end
  endtask

  task automatic test_same_cycle();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd6; bus.alloc_id = 8'd5;
    tick();
    bus.commit_en = 1'b1; bus.commit_dest = 6'd6; bus.commit_id = 8'd5; bus.commit_data = 32'hAA;
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd6; bus.alloc_id = 8'd6;
    tick();
    src_logic[0] = 6'd6;
    settle();
    tests_run++;
    if (src_ready[0] !== 1'b0 || src_tag[0] !== 8'd6 || busy_count !== 7'd1) begin
      tests_failed++; $display("FAIL alloc_wins got ready %b tag %h count %0d want 0 06 1", src_ready[0], src_tag[0], busy_count);
    end
    bus.commit_en = 1'b1; bus.commit_dest = 6'd6; bus.commit_id = 8'd6; bus.commit_data = 32'hBB;
    tick();
    settle();
    tests_run++;
    if (src_ready[0] !== 1'b1 || src_data[0] !== 32'hBB) begin tests_failed++; $display("FAIL r6_final got %b %h want 1 bb", src_ready[0], src_data[0]); end
  endtask

  task automatic test_flash();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd1; bus.alloc_id = 8'h21; tick();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd2; bus.alloc_id = 8'h22; tick();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd7; bus.alloc_id = 8'h27; tick();
    src_logic[0] = 6'd1; src_logic[1] = 6'd7;
    settle();
    tests_run++;
    if (busy_count !== 7'd3 || src_ready !== 2'b00) begin tests_failed++; $display("FAIL three_busy got count %0d ready %b want 3 00", busy_count, src_ready); end
    flash = 1'b1;
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd8; bus.alloc_id = 8'h30;
    bus.commit_en = 1'b1; bus.commit_dest = 6'd1; bus.commit_id = 8'h21; bus.commit_data = 32'h55;
    tick();
    settle();
    tests_run++;
    if (src_ready !== 2'b11 || src_data[0] !== 32'h55 || busy_count !== 7'd0) begin
      tests_failed++; $display("FAIL flash_a got ready %b r1 %h count %0d want 11 55 0", src_ready, src_data[0], busy_count);
    end
    src_logic[0] = 6'd2; src_logic[1] = 6'd8;
    settle();
    tests_run++;
    if (src_ready !== 2'b11) begin tests_failed++; $display("FAIL flash_b got ready %b want 11", src_ready); end
  endtask

  task automatic test_reset_mid();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd10; bus.alloc_id = 8'h40; tick();
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd11; bus.alloc_id = 8'h41; tick();
    rst = 1'b1;
    bus.alloc_en = 1'b1; bus.alloc_dest = 6'd12; bus.alloc_id = 8'h42;
    bus.commit_en = 1'b1; bus.commit_dest = 6'd10; bus.commit_id = 8'h40; bus.commit_data = 32'h77;
    tick();
    rst = 1'b0;
    src_logic[0] = 6'd10; src_logic[1] = 6'd1;
    settle();
    tests_run++;
    if (src_ready !== 2'b11 || src_data[0] !== 32'd0 || src_data[1] !== 32'd0) begin
      tests_failed++; $display("FAIL mid_reset_a got ready %b data %h %h want 11 0 0", src_ready, src_data[0], src_data[1]);
    end
    src_logic[0] = 6'd12; src_logic[1] = 6'd6;
    settle();
    tests_run++;
    if (src_ready !== 2'b11 || src_data[1] !== 32'd0 || src_tag[0] !== 8'd0 || busy_count !== 7'd0) begin
      tests_failed++; $display("FAIL mid_reset_b got ready %b r6 %h tag %h count %0d want 11 0 0 0", src_ready, src_data[1], src_tag[0], busy_count);
    end
  endtask

  initial begin
    #2;
    test_reset();
    test_bypass();
    test_younger_producer();
    test_same_cycle();
    test_flash();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/register_status_file.md
# register_status_file

Architectural register file plus per-register busy/tag scoreboard, sitting directly downstream of the commit queue and beside dispatch. Dispatch marks a logical register busy with the commit id of its producer. The commit queue's in-order commit stream writes the committed value and clears busy when the tag matches. Issue-side source reads return either a ready value or the commit id to wait on, with same-cycle commit bypass.

## Interface
- N_REG, 64, number of logical registers (index width 6)
- DATA_W, 32, register data width
- ID_W, 8, commit id width (matches commit queue size 256)
- clock  in  1  single clock, all state updates on posedge
- reset  in  1  synchronous, active-high
- flash  in  1  pipeline flush (mispredict); clears all busy bits, keeps data
- commit_info  Message.receiver  {dest_logic 6, commit_id 8, data 32}  in-order committed write; reject tied 0
- alloc  Message.receiver  {dest_logic 6, commit_id 8}  dispatch allocated an entry writing dest_logic; reject tied 0
- src_logic[1:0]  in  6 each  source register indices from dispatch
- src_ready[1:0]  out  1 each  operand value available
- src_data[1:0]  out  32 each  operand value (valid when src_ready)
- src_tag[1:0]  out  8 each  producer commit id (valid when ~src_ready)
- busy_count  out  7  number of currently busy registers (registered)

## Operation
- State per register r: data[r] (32), busy[r] (1), tag[r] (8).
- Register 0: reads data 0, ready 1, tag 0; never busy; commit/alloc to r0 ignored.
- Commit (commit_info.en, d = dest_logic != 0): data[d] <= msg.data. If busy[d] && tag[d] == msg.commit_id, busy[d] <= 0; otherwise busy unchanged (a younger producer owns d).
- Alloc (alloc.en, d != 0, ~flash): busy[d] <= 1, tag[d] <= msg.commit_id.
- Same-cycle commit and alloc to same d: commit writes data; alloc wins busy/tag (busy stays 1, tag = alloc id).
- flash: all busy <= 0 that cycle; concurrent alloc ignored; concurrent commit still writes data.
- reset: all data <= 0, busy <= 0, tag <= 0, busy_count <= 0; overrides flash/commit/alloc.
- Source read (per port i, s = src_logic[i]), combinational:
  - s == 0: ready 1, data 0.
  - ~busy[s]: ready 1, data data[s].
  - busy[s] && commit_info.en && commit dest == s && commit id == tag[s]: ready 1, data = commit data (bypass).
  - else ready 0, tag = tag[s], data = data[s] (don't care).
- Reads see pre-edge state: an alloc issued the same cycle does not affect that cycle's reads (an instruction reading its own dest sees the old producer).
- busy_count <= popcount of next-state busy; 0..63, 7 bits, no wrap possible.

## Timing
- Read path: 0-cycle combinational from state, src_logic, commit_info.
- Commit/alloc/flash effects visible on reads the cycle after the edge.
- busy_count lags state by 0 cycles (registered alongside busy).
- No backpressure: both receivers accept every cycle; commit_info.reject = alloc.reject = 0 at all times including reset.
- Outputs after reset: src_ready = 1, src_data = 0, src_tag = 0 for any index, busy_count = 0.

## Test plan
- Reset then read r5, r63 -> ready 1, data 0, busy_count 0; commit to r0 data 0xDEAD -> r0 still reads 0.
- Alloc r3 id 0x10; next cycle read r3 -> ready 0, tag 0x10; commit r3 id 0x10 data 0x1234 same cycle as read -> bypass ready 1, data 0x1234; next cycle busy cleared, busy_count 0.
- Alloc r4 id 1, then alloc r4 id 2; commit r4 id 1 data 7 -> r4 still busy tag 2, data[r4]=7; commit id 2 data 9 -> ready, 9.
- Same cycle commit r6 id 5 (busy tag 5) data 0xAA and alloc r6 id 6 -> next cycle r6 busy tag 6; after commit id 6 data 0xBB -> 0xBB.
- Busy r1,r2,r7 (busy_count 3); flash with concurrent alloc r8 and commit r1 data 0x55 -> all ready, busy_count 0, r1 = 0x55, r8 not busy.
- Reset asserted mid-stream with busy registers and concurrent alloc/commit -> next cycle all data 0, busy_count 0.
